// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of the output-enables of N tri-state pads on one bus net.
// Guarantees a single driver per cycle and inserts turnaround cycles between owners.
module tristate_bus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         oe,
  output logic                     grant_valid,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     turn,
  output logic                     preempt
);

  localparam int IDX_W = $clog2(N_REQ);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W:0]   CAND_N     = (IDX_W + 1)'(N_REQ);
  localparam logic [7:0]       MAX_HOLD_C = 8'(MAX_HOLD);
  localparam logic [3:0]       TURN_C     = 4'(TURNAROUND);
  localparam logic [N_REQ-1:0] ONE_HOT0   = N_REQ'(1);

  logic [1:0]       state_r;
  logic [IDX_W-1:0] rr_ptr_r;
  logic [7:0]       hold_cnt_r;
  logic [3:0]       turn_cnt_r;

  logic             win_found_s;
  logic [IDX_W-1:0] win_idx_s;
  logic [IDX_W:0]   cand_s;
  logic [N_REQ-1:0] owner_mask_s;
  logic             owner_req_s;
  logic             others_req_s;

  // Circular scan from rr_ptr: the first requester found wins. A just-served
  // owner sits last in the order, which also gives a preempted owner lowest priority.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = {1'b0, rr_ptr_r} + (IDX_W + 1)'(k);
      if (cand_s >= CAND_N) begin
        cand_s = cand_s - CAND_N;
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && req[cand_s[IDX_W-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s[IDX_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Owner request and contention from the other requesters.
  always_comb begin
    owner_mask_s = ONE_HOT0 << grant_idx;
    owner_req_s  = req[grant_idx];
    others_req_s = |(req & ~owner_mask_s);
  end

  // Arbitration state machine; every output is a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      hold_cnt_r  <= 8'd0;
      turn_cnt_r  <= 4'd0;
      oe          <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      turn        <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          turn <= 1'b0;
          if (win_found_s) begin
            oe          <= ONE_HOT0 << win_idx_s;
            grant_valid <= 1'b1;
            grant_idx   <= win_idx_s;
            hold_cnt_r  <= 8'd1;
            rr_ptr_r    <= (win_idx_s == LAST_IDX) ? '0 : win_idx_s + IDX_W'(1);
            state_r     <= ST_DRIVE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DRIVE: begin
          if (!owner_req_s) begin
            oe          <= '0;
            grant_valid <= 1'b0;
            turn        <= 1'b1;
            turn_cnt_r  <= TURN_C;
            state_r     <= ST_TURN;
          end else if ((hold_cnt_r == MAX_HOLD_C) && others_req_s) begin
            oe          <= '0;
            grant_valid <= 1'b0;
            preempt     <= 1'b1;
            turn        <= 1'b1;
            turn_cnt_r  <= TURN_C;
            state_r     <= ST_TURN;
          end else if (hold_cnt_r != MAX_HOLD_C) begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        ST_TURN: begin
          if (turn_cnt_r == 4'd1) begin
            turn       <= 1'b0;
            turn_cnt_r <= 4'd0;
            state_r    <= ST_IDLE;
          end else begin
            turn_cnt_r <= turn_cnt_r - 4'd1;
          end
        end
        default: begin
          oe          <= '0;
          grant_valid <= 1'b0;
          turn        <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter with N_REQ=4, TURNAROUND=1, MAX_HOLD=4.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_tristate_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] oe;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic       turn;
  logic       preempt;

  int checks;
  int errors;

  tristate_bus_arbiter #(
    .N_REQ(4),
    .TURNAROUND(1),
    .MAX_HOLD(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .oe(oe),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx),
    .turn(turn),
    .preempt(preempt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset(input logic [3:0] r);
    rst_n = 1'b0;
    req   = r;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({oe, grant_valid, grant_idx, turn} !== 8'b0000_0_00_0) begin
        errors++;
        $display("FAIL reset_state cyc%0d: oe=%b gv=%b gi=%0d turn=%b, want all 0",
                 i, oe, grant_valid, grant_idx, turn);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (oe !== 4'b0001 || grant_idx !== 2'd0 || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: oe=%b gi=%0d gv=%b, want 0001/0/1", oe, grant_idx, grant_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oe;
    logic [1:0] e;
    do_reset(4'b1111);
    for (int i = 0; i < 5; i++) begin
      e      = 2'(i % 4);
      exp_oe = 4'b0001 << e;
      @(negedge clk);
      checks++;
      if (oe !== exp_oe || grant_idx !== e || grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant%0d drive1: oe=%b gi=%0d, want %b/%0d", i, oe, grant_idx, exp_oe, e);
      end
      @(negedge clk);
      checks++;
      if (oe !== exp_oe) begin
        errors++;
        $display("FAIL rr_grant%0d drive2: oe=%b, want %b", i, oe, exp_oe);
      end
      req[e] = 1'b0;
      @(negedge clk);
      checks++;
      if (oe !== 4'b0000 || turn !== 1'b1 || grant_valid !== 1'b0) begin
        errors++;
        $display("FAIL rr_turn%0d: oe=%b turn=%b gv=%b, want 0000/1/0", i, oe, turn, grant_valid);
      end
      req[e] = 1'b1;
      @(negedge clk);
      checks++;
      if (oe !== 4'b0000 || turn !== 1'b0) begin
        errors++;
        $display("FAIL rr_arb%0d: oe=%b turn=%b, want 0000/0", i, oe, turn);
      end
    end
  endtask

  task automatic test_preemption();
    logic [3:0] exp_oe  [8];
    logic       exp_pre [8];
    int         pulses;
    exp_oe  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
    exp_pre = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    pulses  = 0;
    do_reset(4'b0100);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (oe !== exp_oe[i] || preempt !== exp_pre[i]) begin
        errors++;
        $display("FAIL preempt_cyc%0d: oe=%b preempt=%b, want %b/%b",
                 i, oe, preempt, exp_oe[i], exp_pre[i]);
      end
      if (preempt === 1'b1) pulses++;
      if (i == 1) req[0] = 1'b1;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL preempt_pulses: got %0d, want 1", pulses);
    end
  endtask

  task automatic test_uncontested_hold();
    do_reset(4'b0010);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (oe !== 4'b0010 || preempt !== 1'b0 || grant_idx !== 2'd1) begin
        errors++;
        $display("FAIL hold_cyc%0d: oe=%b preempt=%b gi=%0d, want 0010/0/1", i, oe, preempt, grant_idx);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(4'b1000);
    @(negedge clk);
    checks++;
    if (oe !== 4'b1000 || grant_idx !== 2'd3) begin
      errors++;
      $display("FAIL midrst_drive: oe=%b gi=%0d, want 1000/3", oe, grant_idx);
    end
    rst_n = 1'b0;
    req   = 4'b1001;
    @(negedge clk);
    checks++;
    if (oe !== 4'b0000 || grant_valid !== 1'b0 || turn !== 1'b0 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL midrst_clear: oe=%b gv=%b turn=%b gi=%0d, want 0000/0/0/0",
               oe, grant_valid, turn, grant_idx);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (oe !== 4'b0001 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL midrst_regrant: oe=%b gi=%0d, want 0001/0", oe, grant_idx);
    end
  endtask

  task automatic test_random_single_driver();
    logic [3:0] prev_oe;
    int         bad;
    bad     = 0;
    prev_oe = 4'b0000;
    do_reset(4'b0000);
    for (int i = 0; i < 3000; i++) begin
      req = 4'($urandom_range(0, 15));
      @(negedge clk);
      if ($countones(oe) > 1 || grant_valid !== (|oe) ||
          (prev_oe != 4'b0000 && oe != 4'b0000 && oe != prev_oe) ||
          (preempt === 1'b1 && (oe !== 4'b0000 || turn !== 1'b1))) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random_cyc%0d: oe=%b prev=%b gv=%b preempt=%b turn=%b",
                   i, oe, prev_oe, grant_valid, preempt, turn);
      end
      prev_oe = oe;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_single_driver: %0d bad cycles, want 0", bad);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 4'b0000;
    test_reset();
    test_round_robin();
    test_preemption();
    test_uncontested_hold();
    test_reset_mid();
    test_random_single_driver();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
